// File: rtl/apb_modport.sv
// AHB-Lite slave to APB master bridge with four decoded peripheral selects.
// Optional MODPORT_ERR_RESP_EN: two-cycle ERROR response for out-of-range transfers.
`timescale 1ns/1ps
module apb_modport (
  input  logic        clk,
  input  logic        Hresetn,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic [3:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  input  logic [31:0] Prdata
);

  typedef enum logic [2:0] {
    IDLE, CAPT, SETUP, ACCESS, ERR1, ERR2
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        write_q;
  logic [3:0]  sel_q;

  logic       active;
  logic       in_range;
  logic       valid;
  logic [3:0] dec;

  assign active   = Hreadyin & Htrans[1];
  assign in_range = (Haddr[31:28] == 4'h8);
  assign valid    = active & in_range;

  always_comb begin
    dec = 4'b0000;
    unique case (Haddr[27:26])
      2'b00: dec = 4'b0001;
      2'b01: dec = 4'b0010;
      2'b10: dec = 4'b0100;
      2'b11: dec = 4'b1000;
    endcase
  end

  always_ff @(posedge clk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      Hrdata    <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= 2'b00;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Pselx     <= '0;
          Penable   <= 1'b0;
          Hresp     <= 2'b00;
          Hreadyout <= 1'b1;
          if (valid) begin
            addr_q    <= Haddr;
            write_q   <= Hwrite;
            sel_q     <= dec;
            Hreadyout <= 1'b0;
            state     <= CAPT;
          end
`ifdef MODPORT_ERR_RESP_EN
          else if (active) begin
            Hresp     <= 2'b01;
            Hreadyout <= 1'b0;
            state     <= ERR1;
          end
`endif
        end
        // APB address/control/data all launch together into SETUP
        CAPT: begin
          Paddr   <= addr_q;
          Pwrite  <= write_q;
          Pwdata  <= Hwdata;
          Pselx   <= sel_q;
          Penable <= 1'b0;
          state   <= SETUP;
        end
        SETUP: begin
          Penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (!Pwrite) Hrdata <= Prdata;
          Pselx     <= '0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
          state     <= IDLE;
        end
        ERR1: begin
          Hreadyout <= 1'b1;
          state     <= ERR2;
        end
        ERR2: begin
          Hresp <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: directed scenarios plus randomized
// transfers against a transaction-level model of the bridge.
`timescale 1ns/1ps
module tb_apb_modport;

  logic        clk = 1'b0;
  logic        Hresetn;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic        Hreadyin;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Prdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] model_hrdata;

  int          o_t0;
  logic        o_rdy1, o_rdy2, o_rdy3, o_rdy4;
  logic [3:0]  o_sel1, o_sel2, o_sel3, o_sel4;
  logic        o_en2, o_en3, o_en4;
  logic [31:0] o_addr2, o_addr3, o_wd2, o_hrd4;
  logic        o_wr2;
  logic [1:0]  o_resp4;

  apb_modport dut (
    .clk       (clk),
    .Hresetn   (Hresetn),
    .Haddr     (Haddr),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Hwdata    (Hwdata),
    .Hrdata    (Hrdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Prdata    (Prdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp_sel(input logic [31:0] a);
    return 4'b0001 << a[27:26];
  endfunction

  // Drives one transfer from its address phase (T0) to T4 and snapshots
  // the bus at each cycle; the calling test decides what to compare.
  task automatic run_xfer(input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input logic [31:0] rd);
    o_t0 = cyc;
    Haddr = a; Htrans = 2'b10; Hwrite = w; Hreadyin = 1'b1;
    @(posedge clk); #1;
    Htrans = 2'b00; Haddr = $urandom; Hwrite = 1'($urandom); Hwdata = wd;
    o_rdy1 = Hreadyout; o_sel1 = Pselx;
    @(posedge clk); #1;
    o_sel2 = Pselx; o_en2 = Penable; o_addr2 = Paddr;
    o_wr2 = Pwrite; o_wd2 = Pwdata; o_rdy2 = Hreadyout;
    Prdata = rd;
    @(posedge clk); #1;
    o_sel3 = Pselx; o_en3 = Penable; o_addr3 = Paddr; o_rdy3 = Hreadyout;
    @(posedge clk); #1;
    o_rdy4 = Hreadyout; o_sel4 = Pselx; o_en4 = Penable;
    o_hrd4 = Hrdata; o_resp4 = Hresp;
    Prdata = $urandom;
    if (!w) model_hrdata = rd;
  endtask

  task automatic test_reset;
    Hresetn = 1'b0;
    #12;
    checks++; if (Hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b expected 1", Hreadyout); end
    checks++; if (Hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b expected 00", Hresp); end
    checks++; if (Hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", Hrdata); end
    checks++; if (Paddr !== 32'h0 || Pwdata !== 32'h0) begin errors++; $display("FAIL reset_paddr_pwdata: got %h/%h expected 0/0", Paddr, Pwdata); end
    checks++; if (Pselx !== 4'h0 || Penable !== 1'b0 || Pwrite !== 1'b0) begin errors++; $display("FAIL reset_apb_ctl: got sel=%b en=%b wr=%b expected 0", Pselx, Penable, Pwrite); end
    @(negedge clk); Hresetn = 1'b1;
    @(posedge clk); #1;
    model_hrdata = 32'h0;
  endtask

  task automatic test_single_write;
    run_xfer(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 32'h5555_AAAA);
    checks++; if (o_rdy1 !== 1'b0) begin errors++; $display("FAIL wr_t1_hready: got %b expected 0", o_rdy1); end
    checks++; if (o_sel2 !== 4'b0001 || o_en2 !== 1'b0) begin errors++; $display("FAIL wr_t2_setup: got sel=%b en=%b expected 0001/0", o_sel2, o_en2); end
    checks++; if (o_addr2 !== 32'h8000_0010) begin errors++; $display("FAIL wr_t2_paddr: got %h expected 80000010", o_addr2); end
    checks++; if (o_wd2 !== 32'hDEAD_BEEF || o_wr2 !== 1'b1) begin errors++; $display("FAIL wr_t2_pwdata: got %h wr=%b expected deadbeef/1", o_wd2, o_wr2); end
    checks++; if (o_en3 !== 1'b1 || o_sel3 !== 4'b0001) begin errors++; $display("FAIL wr_t3_access: got en=%b sel=%b expected 1/0001", o_en3, o_sel3); end
    checks++; if (o_rdy4 !== 1'b1 || o_sel4 !== 4'b0) begin errors++; $display("FAIL wr_t4_done: got rdy=%b sel=%b expected 1/0000", o_rdy4, o_sel4); end
    checks++; if (o_hrd4 !== model_hrdata) begin errors++; $display("FAIL wr_hrdata_kept: got %h expected %h", o_hrd4, model_hrdata); end
    checks++; if (Paddr !== 32'h8000_0010 || Pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_idle_hold: got %h/%h expected 80000010/deadbeef", Paddr, Pwdata); end
  endtask

  task automatic test_single_read;
    run_xfer(32'h8800_0004, 1'b0, 32'h0, 32'h1234_5678);
    checks++; if (o_sel2 !== 4'b0100 || o_wr2 !== 1'b0) begin errors++; $display("FAIL rd_t2: got sel=%b wr=%b expected 0100/0", o_sel2, o_wr2); end
    checks++; if (o_hrd4 !== 32'h1234_5678) begin errors++; $display("FAIL rd_t4_hrdata: got %h expected 12345678", o_hrd4); end
    checks++; if (o_resp4 !== 2'b00 || o_rdy4 !== 1'b1) begin errors++; $display("FAIL rd_t4_resp: got resp=%b rdy=%b expected 00/1", o_resp4, o_rdy4); end
  endtask

  task automatic test_reset_mid_access;
    Haddr = 32'h8C00_0000; Htrans = 2'b10; Hwrite = 1'b0; Hreadyin = 1'b1;
    @(posedge clk); #1; Htrans = 2'b00;
    @(posedge clk); #1; Prdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    checks++; if (Penable !== 1'b1) begin errors++; $display("FAIL rst_mid_access_en: got %b expected 1", Penable); end
    Hresetn = 1'b0;
    #1;
    checks++; if (Pselx !== 4'b0 || Penable !== 1'b0) begin errors++; $display("FAIL rst_mid_apb: got sel=%b en=%b expected 0000/0", Pselx, Penable); end
    checks++; if (Hreadyout !== 1'b1 || Hrdata !== 32'h0) begin errors++; $display("FAIL rst_mid_ahb: got rdy=%b hrdata=%h expected 1/0", Hreadyout, Hrdata); end
    @(negedge clk); Hresetn = 1'b1;
    @(posedge clk); #1;
    model_hrdata = 32'h0;
  endtask

  task automatic test_decode_sweep;
    logic [31:0] base;
    for (int i = 0; i < 4; i++) begin
      base = 32'h8000_0000 | (32'(i) << 26);
      run_xfer(base, 1'b1, $urandom, $urandom);
      checks++; if (o_sel2 !== (4'b0001 << i)) begin errors++; $display("FAIL decode_%0d: got %b expected %b", i, o_sel2, 4'b0001 << i); end
    end
  endtask

  task automatic test_back_to_back;
    int t0a;
    logic [3:0] sel4a;
    logic [31:0] rd;
    rd = $urandom;
    run_xfer(32'h8400_0000, 1'b1, 32'h0BAD_F00D, 32'h0);
    t0a = o_t0; sel4a = o_sel4;
    run_xfer(32'h8400_0008, 1'b0, 32'h0, rd);
    checks++; if (o_t0 + 2 !== t0a + 6) begin errors++; $display("FAIL b2b_setup_cycle: got T%0d expected T6", o_t0 + 2 - t0a); end
    checks++; if (sel4a !== 4'b0 || o_sel1 !== 4'b0) begin errors++; $display("FAIL b2b_overlap: got T4=%b T5=%b expected 0000", sel4a, o_sel1); end
    checks++; if (o_sel2 !== 4'b0010 || o_wr2 !== 1'b0 || o_addr2 !== 32'h8400_0008) begin errors++; $display("FAIL b2b_second_setup: got sel=%b wr=%b addr=%h", o_sel2, o_wr2, o_addr2); end
    checks++; if (o_hrd4 !== rd) begin errors++; $display("FAIL b2b_hrdata: got %h expected %h", o_hrd4, rd); end
  endtask

  // One invalid address phase; err selects the two-cycle ERROR expectation.
  task automatic invalid_phase(input logic [31:0] a, input logic [1:0] tr,
                               input logic rdy, input logic err, input string nm);
    Haddr = a; Htrans = tr; Hreadyin = rdy; Hwrite = 1'($urandom);
    @(posedge clk); #1;
    Htrans = 2'b00; Hreadyin = 1'b1;
    checks++; if (Hreadyout !== !err || Hresp !== {1'b0, err} || Pselx !== 4'b0)
      begin errors++; $display("FAIL %s_c1: got rdy=%b resp=%b sel=%b expected %b/%b/0000", nm, Hreadyout, Hresp, Pselx, !err, {1'b0, err}); end
    @(posedge clk); #1;
    if (err) begin
      checks++; if (Hreadyout !== 1'b1 || Hresp !== 2'b01) begin errors++; $display("FAIL %s_c2: got rdy=%b resp=%b expected 1/01", nm, Hreadyout, Hresp); end
      @(posedge clk); #1;
    end
    checks++; if (Hresp !== 2'b00 || Pselx !== 4'b0 || Hreadyout !== 1'b1) begin errors++; $display("FAIL %s_after: got rdy=%b resp=%b sel=%b expected 1/00/0000", nm, Hreadyout, Hresp, Pselx); end
  endtask

  function automatic logic err_mode;
`ifdef MODPORT_ERR_RESP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_invalid;
    invalid_phase(32'h9000_0000, 2'b10, 1'b1, err_mode(), "inv_range");
    invalid_phase(32'h8000_0000, 2'b00, 1'b1, 1'b0, "inv_htrans_idle");
    invalid_phase(32'h8000_0000, 2'b01, 1'b1, 1'b0, "inv_htrans_busy");
    invalid_phase(32'h8000_0000, 2'b10, 1'b0, 1'b0, "inv_hreadyin");
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd;
    logic w;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      if (kind < 3) begin
        a = {4'h8, 28'($urandom)};
        w = 1'($urandom); wd = $urandom; rd = $urandom;
        run_xfer(a, w, wd, rd);
        checks++; if (o_rdy1 !== 1'b0 || o_rdy2 !== 1'b0 || o_rdy3 !== 1'b0) begin errors++; $display("FAIL rnd_wait_%0d: got %b%b%b expected 000", i, o_rdy1, o_rdy2, o_rdy3); end
        checks++; if (o_sel2 !== exp_sel(a) || o_en2 !== 1'b0 || o_sel1 !== 4'b0) begin errors++; $display("FAIL rnd_setup_%0d: got sel=%b en=%b expected %b/0", i, o_sel2, o_en2, exp_sel(a)); end
        checks++; if (o_addr2 !== a || o_wr2 !== w || o_wd2 !== wd) begin errors++; $display("FAIL rnd_apb_%0d: got %h/%b/%h expected %h/%b/%h", i, o_addr2, o_wr2, o_wd2, a, w, wd); end
        checks++; if (o_sel3 !== exp_sel(a) || o_en3 !== 1'b1 || o_addr3 !== a) begin errors++; $display("FAIL rnd_access_%0d: got sel=%b en=%b addr=%h", i, o_sel3, o_en3, o_addr3); end
        checks++; if (o_rdy4 !== 1'b1 || o_sel4 !== 4'b0 || o_en4 !== 1'b0 || o_resp4 !== 2'b00) begin errors++; $display("FAIL rnd_end_%0d: got rdy=%b sel=%b en=%b resp=%b", i, o_rdy4, o_sel4, o_en4, o_resp4); end
        checks++; if (o_hrd4 !== model_hrdata) begin errors++; $display("FAIL rnd_hrdata_%0d: got %h expected %h", i, o_hrd4, model_hrdata); end
      end else if (kind == 3) begin
        a = $urandom;
        if (a[31:28] == 4'h8) a[31:28] = 4'h9;
        invalid_phase(a, {1'b1, 1'($urandom)}, 1'b1, err_mode(), "rnd_range");
      end else if (kind == 4) begin
        invalid_phase({4'h8, 28'($urandom)}, {1'b0, 1'($urandom)}, 1'b1, 1'b0, "rnd_htrans");
      end else begin
        invalid_phase($urandom, {1'b1, 1'($urandom)}, 1'b0, 1'b0, "rnd_hreadyin");
      end
    end
    checks++; if (Hrdata !== model_hrdata) begin errors++; $display("FAIL rnd_final_hrdata: got %h expected %h", Hrdata, model_hrdata); end
  endtask

  initial begin
    Hresetn = 1'b0; Haddr = '0; Htrans = 2'b00; Hwrite = 1'b0;
    Hreadyin = 1'b1; Hwdata = '0; Prdata = '0;
    model_hrdata = '0;
    test_reset;
    test_single_write;
    test_single_read;
    test_reset_mid_access;
    test_decode_sweep;
    test_back_to_back;
    test_invalid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
